ysyx_23060061_axil_arbiter: RTL

Two-master to one-slave AXI-Lite arbiter placed directly upstream of the SRAM slave. Master 0 is the instruction fetch unit (read-only). Master 1 is the load/store unit (read and write). The arbiter grants exactly one transaction at a time, routes that master's channels to the slave, and releases the grant after the response handshake completes.

---
 rtl/ysyx_23060061_axil_arbiter_pkg.sv | 16 +
 rtl/ysyx_23060061_arb_pick.sv | 15 +
 rtl/ysyx_23060061_axil_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060061_axil_arbiter_pkg.sv
// Shared definitions for the two-master AXI-Lite arbiter: state encoding and AXI response codes.
package ysyx_23060061_axil_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_WR1  = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060061_arb_pick.sv
// Combinational winner selection between the IFU (req0) and the LSU side (req1).
module ysyx_23060061_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    // last_grant=1 means the LSU side won the previous grant, so a tie goes to m0.
    // Holding last_grant at 0 degenerates into fixed m1 > m0 priority.
    assign gnt1 = req1 & (~req0 | ~last_grant);
    assign gnt0 = req0 & ~gnt1;

endmodule

// File: rtl/ysyx_23060061_axil_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-Lite arbiter, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise m1 always beats m0.
module ysyx_23060061_axil_arbiter
    import ysyx_23060061_axil_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on the clk edge where valid && ready are both 1;
    // valid plus payload are held by the source until then, ready may toggle freely.

    arb_state_e state, state_nxt;
    logic       wr_req1, req1, gnt0, gnt1, last_grant;

    // The slave only takes AW and W together, so a write request needs both.
    assign wr_req1 = m1_awvalid & m1_wvalid;
    assign req1    = wr_req1 | m1_arvalid;

    ysyx_23060061_arb_pick u_pick (
        .req0       (m0_arvalid),
        .req1       (req1),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b0;
        end else if (state == ST_IDLE && (gnt0 || gnt1)) begin
            last_grant <= gnt1;
        end
    end
`else
    assign last_grant = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gnt1) begin
                    state_nxt = wr_req1 ? ST_WR1 : ST_RD1;
                end else if (gnt0) begin
                    state_nxt = ST_RD0;
                end
            end
            ST_RD0, ST_RD1: if (s_rvalid && s_rready) state_nxt = ST_IDLE;
            ST_WR1:         if (s_bvalid && s_bready) state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RESP_OKAY;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = RESP_OKAY;
        m1_bvalid  = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state)
            ST_RD0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            ST_RD1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            ST_WR1: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid;
                m1_awready = s_awready;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid;
                m1_wready  = s_wready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule
